// File: rtl/kernel_loader_if.sv
// Bundles the weight-memory read port, kernel write port, pixel stream and status
// of kernel_loader. The loader is the slave; the environment driving it is the master.
interface kernel_loader_if;
  logic              iStart;
  logic              oMemRd;
  logic [4:0]        oMemAddr;
  logic signed [7:0] iMemData;
  logic              iMemValid;
  logic signed [7:0] oW;
  logic [4:0]        oADDR;
  logic              oWren;
  logic signed [7:0] iPixel;
  logic              iPixelValid;
  logic              oPixelReady;
  logic signed [7:0] oX;
  logic              oValid;
  logic              oBusy;
  logic              oDone;
  logic              oErr;
  logic              oLoaded;

  modport slave (
    input  iStart, iMemData, iMemValid, iPixel, iPixelValid,
    output oMemRd, oMemAddr, oW, oADDR, oWren, oPixelReady, oX, oValid,
           oBusy, oDone, oErr, oLoaded
  );

  modport master (
    output iStart, iMemData, iMemValid, iPixel, iPixelValid,
    input  oMemRd, oMemAddr, oW, oADDR, oWren, oPixelReady, oX, oValid,
           oBusy, oDone, oErr, oLoaded
  );
endinterface

// File: rtl/kernel_loader.sv
// Copies K_SIZE weights from a weight memory into the kernel store, then forwards pixels.
// 3 cycles per weight with 1-cycle memory; pixels forwarded with 1-cycle latency once loaded.
module kernel_loader #(
  parameter int K_SIZE  = 25,
  parameter int TIMEOUT = 255
) (
  input logic           iCLK,
  input logic           iRSTn,
  kernel_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;

  localparam int            WW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [4:0]    LAST_IDX  = 5'(K_SIZE - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic signed [7:0] data_q, data_d;
  logic              loaded_q, loaded_d;
  logic              err_q, err_d;
  logic signed [7:0] x_q, x_d;
  logic              valid_q, valid_d;

  logic mem_rd, wren, busy, done, pix_rdy;

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      data_q   <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
      x_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      x_q      <= x_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    data_d   = data_q;
    loaded_d = loaded_q;
    err_d    = 1'b0;
    x_d      = x_q;
    valid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.iStart) begin
          cnt_d    = '0;
          loaded_d = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        wait_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Data arriving on the final allowed wait cycle still wins over the timeout.
        if (bus.iMemValid) begin
          data_d  = bus.iMemData;
          state_d = WRITE;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      WRITE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          state_d = REQ;
        end
      end
      DONE: begin
        loaded_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.iPixelValid && pix_rdy) begin
      x_d     = bus.iPixel;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    mem_rd  = (state_q == REQ);
    wren    = (state_q == WRITE);
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    pix_rdy = loaded_q && !busy;
  end

  assign bus.oMemRd      = mem_rd;
  assign bus.oMemAddr    = cnt_q;
  assign bus.oWren       = wren;
  assign bus.oADDR       = cnt_q;
  assign bus.oW          = data_q;
  assign bus.oBusy       = busy;
  assign bus.oDone       = done;
  assign bus.oErr        = err_q;
  assign bus.oLoaded     = loaded_q;
  assign bus.oPixelReady = pix_rdy;
  assign bus.oX          = x_q;
  assign bus.oValid      = valid_q;

endmodule

// File: tb/tb_kernel_loader.sv
// Directed bench for kernel_loader: a cycle-stepped memory model answers reads with a chosen
// latency while every write, read address, done/err timing and pixel transfer is checked.
module tb_kernel_loader;

  localparam int MAXC = 400;

  logic iCLK = 1'b0;
  logic iRSTn;
  int   vectors = 0;
  int   miscompares = 0;

  kernel_loader_if bus ();

  kernel_loader #(.K_SIZE(25), .TIMEOUT(255)) dut (
    .iCLK (iCLK),
    .iRSTn(iRSTn),
    .bus  (bus.slave)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_memwr"}, {bus.oMemRd, bus.oMemAddr, bus.oW, bus.oADDR, bus.oWren}, 0);
    chk({tag, "_stat"},  {bus.oPixelReady, bus.oX, bus.oValid, bus.oBusy, bus.oDone,
                          bus.oErr, bus.oLoaded}, 0);
  endtask

  // Pulses iStart, then plays the memory cycle by cycle until oDone/oErr, the cycle
  // budget, or the write of abort_addr (which asserts reset and returns at once).
  task automatic run_load(input int lat, input int dead, input int noise, input int abort_addr,
                          output int done_cyc, output int err_cyc, output int nwr);
    int rd_t, rd_a, exp_a, exp_r;
    done_cyc = -1; err_cyc = -1; nwr = 0;
    rd_t = -100; rd_a = 0; exp_a = 0; exp_r = 0;
    @(negedge iCLK);
    bus.iStart = 1'b1;
    for (int t = 1; t <= MAXC; t++) begin
      @(negedge iCLK);
      bus.iStart = (noise != 0 && t == 20);
      if (bus.oMemRd) begin
        chk("rd_addr", bus.oMemAddr, exp_r);
        exp_r++;
        rd_t = t;
        rd_a = int'(bus.oMemAddr);
      end
      if (bus.oWren) begin
        chk("wr_addr", bus.oADDR, exp_a);
        chk("wr_data", $signed(bus.oW), exp_a - 12);
        chk("wr_no_rd", bus.oMemRd, 0);
        exp_a++;
        if (abort_addr >= 0 && int'(bus.oADDR) == abort_addr) begin
          bus.iMemValid = 1'b0;
          bus.iStart    = 1'b0;
          iRSTn         = 1'b0;
          nwr           = exp_a;
          return;
        end
      end
      if (bus.oDone) done_cyc = t;
      if (bus.oErr)  err_cyc = t;
      if (t == rd_t + lat && rd_a != dead) begin
        bus.iMemValid = 1'b1;
        bus.iMemData  = 8'(rd_a - 12);
      end else if (noise != 0 && bus.oMemRd) begin
        bus.iMemValid = 1'b1;
        bus.iMemData  = 8'sh55;
      end else begin
        bus.iMemValid = 1'b0;
        bus.iMemData  = '0;
      end
      if (done_cyc >= 0 || err_cyc >= 0) break;
    end
    bus.iStart    = 1'b0;
    bus.iMemValid = 1'b0;
    bus.iMemData  = '0;
    nwr = exp_a;
  endtask

  initial begin
    int done_c, err_c, nw;
    logic signed [7:0] pix [3];
    pix[0] = -8'sd5; pix[1] = 8'sd0; pix[2] = 8'sd127;

    iRSTn = 1'b0;
    bus.iStart = 1'b0; bus.iMemValid = 1'b0; bus.iMemData = '0;
    bus.iPixel = '0;   bus.iPixelValid = 1'b0;
    repeat (3) @(negedge iCLK);
    chk_all_zero("reset");
    iRSTn = 1'b1;

    // Pixels before any load are dropped.
    for (int i = 0; i < 3; i++) begin
      bus.iPixelValid = 1'b1;
      bus.iPixel      = pix[i];
      @(negedge iCLK);
      chk("pix_drop_valid", bus.oValid, 0);
    end
    bus.iPixelValid = 1'b0;

    run_load(1, -1, 0, -1, done_c, err_c, nw);
    chk("lat1_done_cyc", done_c, 76);
    chk("lat1_nwr", nw, 25);
    chk("lat1_err", err_c, -1);
    @(negedge iCLK);
    chk("lat1_loaded", bus.oLoaded, 1);
    chk("lat1_busy", bus.oBusy, 0);
    chk("lat1_pix_rdy", bus.oPixelReady, 1);

    // Pixels after load appear one cycle later.
    bus.iPixelValid = 1'b1;
    bus.iPixel      = pix[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      chk("pix_valid", bus.oValid, 1);
      chk("pix_x", $signed(bus.oX), pix[i]);
      if (i < 2) bus.iPixel = pix[i+1];
      else       bus.iPixelValid = 1'b0;
    end
    @(negedge iCLK);
    chk("pix_idle_valid", bus.oValid, 0);
    chk("pix_hold_x", $signed(bus.oX), 127);

    run_load(4, -1, 0, -1, done_c, err_c, nw);
    chk("lat4_done_cyc", done_c, 151);
    chk("lat4_nwr", nw, 25);

    // Stray iStart and out-of-WAIT iMemValid must not disturb the load.
    run_load(1, -1, 1, -1, done_c, err_c, nw);
    chk("noise_done_cyc", done_c, 76);
    chk("noise_nwr", nw, 25);

    run_load(1, 7, 0, -1, done_c, err_c, nw);
    chk("tmo_err_cyc", err_c, 278);
    chk("tmo_nwr", nw, 7);
    chk("tmo_done", done_c, -1);
    chk("tmo_busy", bus.oBusy, 0);
    chk("tmo_loaded", bus.oLoaded, 0);
    @(negedge iCLK);
    chk("tmo_err_pulse", bus.oErr, 0);

    // Load fully, then reset on the write of weight 10.
    run_load(1, -1, 0, -1, done_c, err_c, nw);
    chk("pre_abort_done", done_c, 76);
    run_load(1, -1, 0, 10, done_c, err_c, nw);
    chk("abort_nwr", nw, 11);
    @(negedge iCLK);
    chk_all_zero("abort");
    iRSTn = 1'b1;
    repeat (4) @(negedge iCLK);
    chk("abort_idle", {bus.oWren, bus.oBusy, bus.oLoaded}, 0);

    run_load(1, -1, 0, -1, done_c, err_c, nw);
    chk("reload_done_cyc", done_c, 76);
    chk("reload_nwr", nw, 25);
    @(negedge iCLK);
    chk("reload_loaded", bus.oLoaded, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
